// File: rtl/intt_stage_controller_pkg.sv
// Shared definitions for the INTT stage controller: FSM states, twiddle modes
// and the stage decode helpers also used by the forward-NTT controller.
package intt_stage_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SWAP  = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_GROUP  = 2'd1;
  localparam logic [1:0] MODE_CONST  = 2'd2;

  localparam int I_W = 10;

  // First stage uses direct twiddles; the last LOG_CORE_COUNT+1 stages use a constant per core.
  function automatic logic [1:0] mode_decode(input logic [3:0] stage, input int log_n,
                                             input int log_core_count);
    if (int'(stage) == log_n) return MODE_DIRECT;
    if (int'(stage) <= log_core_count + 1) return MODE_CONST;
    return MODE_GROUP;
  endfunction

  // Shift that turns a read address into a butterfly group index; clamps at 0 in stage LOG_N.
  function automatic int group_shift(input logic [3:0] stage, input int log_n);
    int sh;
    sh = log_n - 1 - int'(stage);
    return (sh < 0) ? 0 : sh;
  endfunction

endpackage

// File: rtl/intt_stage_controller_delay_line.sv
// Resettable shift register; carries read-side strobe/address/tag to the write-back side.
module intt_stage_controller_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
    end else begin
      taps[0] <= din;
      for (int k = 1; k < DEPTH; k++) taps[k] <= taps[k-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/intt_stage_controller.sv
// Stage sequencer for an in-place Gentleman-Sande INTT: one RUN/DRAIN/SWAP pass per
// stage, registered outputs, and a write-back pipe matching the butterfly latency.
module intt_stage_controller
  import intt_stage_controller_pkg::*;
#(
  parameter int LOG_N          = 12,
  parameter int LOG_CORE_COUNT = 4,
  parameter int ADDR_W         = 9,
  parameter int BF_LATENCY     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        log_m,
  output logic [1:0]        mode,
  output logic [ADDR_W-1:0] upper_read_address,
  output logic [ADDR_W-1:0] lower_read_address,
  output logic [I_W-1:0]    upper_i,
  output logic [I_W-1:0]    lower_i,
  output logic              read_select,
  output logic              write_select,
  output logic              input_select,
  output logic              write_enable,
  output logic [ADDR_W-1:0] upper_write_address,
  output logic [ADDR_W-1:0] lower_write_address,
  output logic              out_valid,
  output ctrl_state_t       fsm_state
);

  localparam int PIPE_LAT = BF_LATENCY + 1;
  localparam int DRAIN_W  = $clog2(PIPE_LAT + 1);
  localparam int DL_W     = ADDR_W + 2;
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = '1;
  localparam logic [3:0]         LOG_N_V    = 4'(LOG_N);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  ctrl_state_t state, state_next;

  logic [ADDR_W-1:0]  cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [3:0]         lm;
  logic               sel;
  logic               first_stage;
  logic               rd_strobe_n, busy_n, done_n;
  logic               rd_strobe_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [I_W-1:0]     i_q;
  logic [DL_W-1:0]    dl_in, dl_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (cnt == LAST_ADDR) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_next = (lm == 4'd1) ? ST_DONE : ST_SWAP;
      ST_SWAP:  state_next = ST_RUN;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_strobe_n = (state == ST_RUN);
    busy_n      = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_SWAP);
    done_n      = (state == ST_DONE);
  end

  // Stage bookkeeping: read counter, drain timer, stage number and bank parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      drain_cnt   <= '0;
      lm          <= LOG_N_V;
      sel         <= 1'b0;
      first_stage <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          cnt         <= '0;
          lm          <= LOG_N_V;
          sel         <= 1'b0;
          first_stage <= 1'b1;
        end
        ST_RUN: begin
          if (cnt != LAST_ADDR) cnt <= cnt + 1'b1;
          drain_cnt <= '0;
        end
        ST_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        ST_SWAP: begin
          sel         <= ~sel;
          lm          <= lm - 4'd1;
          cnt         <= '0;
          first_stage <= 1'b0;
        end
        ST_DONE: first_stage <= 1'b0;
        default: ;
      endcase
    end
  end

  // Every externally visible signal is registered one cycle behind the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      log_m        <= LOG_N_V;
      mode         <= MODE_DIRECT;
      rd_addr_q    <= '0;
      i_q          <= '0;
      read_select  <= 1'b0;
      write_select <= 1'b1;
      input_select <= 1'b0;
      rd_strobe_q  <= 1'b0;
    end else begin
      busy         <= busy_n;
      done         <= done_n;
      log_m        <= lm;
      mode         <= mode_decode(lm, LOG_N, LOG_CORE_COUNT);
      rd_addr_q    <= cnt;
      i_q          <= 10'(cnt >> group_shift(lm, LOG_N));
      read_select  <= sel;
      write_select <= ~sel;
      input_select <= first_stage;
      rd_strobe_q  <= rd_strobe_n;
    end
  end

  assign upper_read_address = rd_addr_q;
  assign lower_read_address = rd_addr_q;
  assign upper_i            = i_q;
  assign lower_i            = i_q;
  assign fsm_state          = state;

  assign dl_in = {rd_strobe_q, rd_addr_q, (log_m == 4'd1)};

  intt_stage_controller_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (PIPE_LAT)
  ) u_write_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign write_enable        = dl_out[DL_W-1];
  assign upper_write_address = dl_out[ADDR_W:1];
  assign lower_write_address = dl_out[ADDR_W:1];
  assign out_valid           = dl_out[DL_W-1] & dl_out[0];

endmodule

// File: tb/tb_intt_stage_controller.sv
// Directed bench for intt_stage_controller: stage timing, modes, group index,
// write-back pipe via an expected queue, ignored starts and mid-run reset.
module tb_intt_stage_controller;
  import intt_stage_controller_pkg::*;

  localparam int W      = 32;
  localparam int PERIOD = 520;
  localparam int TOTAL  = 6240;

  logic       clk, rst, start;
  logic       busy, done, read_select, write_select, input_select, write_enable, out_valid;
  logic [3:0] log_m;
  logic [1:0] mode;
  logic [8:0] upper_read_address, lower_read_address, upper_write_address, lower_write_address;
  logic [9:0] upper_i, lower_i;
  ctrl_state_t fsm_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  intt_stage_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .busy                (busy),
    .done                (done),
    .log_m               (log_m),
    .mode                (mode),
    .upper_read_address  (upper_read_address),
    .lower_read_address  (lower_read_address),
    .upper_i             (upper_i),
    .lower_i             (lower_i),
    .read_select         (read_select),
    .write_select        (write_select),
    .input_select        (input_select),
    .write_enable        (write_enable),
    .upper_write_address (upper_write_address),
    .lower_write_address (lower_write_address),
    .out_valid           (out_valid),
    .fsm_state           (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_mode(input int lm);
    if (lm == 12) return 2'd0;
    else if (lm <= 5) return 2'd2;
    else return 2'd1;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_we"},    32'(write_enable), 32'd0);
    check({tag, "_ov"},    32'(out_valid), 32'd0);
    check({tag, "_insel"}, 32'(input_select), 32'd0);
    check({tag, "_ura"},   32'(upper_read_address), 32'd0);
    check({tag, "_lra"},   32'(lower_read_address), 32'd0);
    check({tag, "_uwa"},   32'(upper_write_address), 32'd0);
    check({tag, "_lwa"},   32'(lower_write_address), 32'd0);
    check({tag, "_ui"},    32'(upper_i), 32'd0);
    check({tag, "_li"},    32'(lower_i), 32'd0);
    check({tag, "_logm"},  32'(log_m), 32'd12);
    check({tag, "_mode"},  32'(mode), 32'd0);
    check({tag, "_rsel"},  32'(read_select), 32'd0);
    check({tag, "_wsel"},  32'(write_select), 32'd1);
    check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
  endtask

  // driver + model: start pulse at edge T, then cycles T+1..T+k_last with
  // optional start pokes that must be ignored.
  task automatic run_checked(input int k_last, input int poke_a, input int poke_b);
    int s, p, lm;
    logic last;
    logic [W-1:0] e;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t0_busy", 32'(busy), 32'd0);
    check("t0_done", 32'(done), 32'd0);
    for (int k = 1; k <= k_last; k++) begin
      start = (k == poke_a) || (k == poke_b);
      step();
      start = 1'b0;
      if (k < TOTAL) begin
        s  = (k - 1) / PERIOD;
        p  = (k - 1) % PERIOD;
        lm = 12 - s;
        check("busy",  32'(busy), 32'd1);
        check("done",  32'(done), 32'd0);
        check("log_m", 32'(log_m), 32'(lm));
        check("mode",  32'(mode), 32'(exp_mode(lm)));
        check("rsel",  32'(read_select), 32'(s % 2));
        check("wsel",  32'(write_select), 32'(1 - (s % 2)));
        check("insel", 32'(input_select), (s == 0) ? 32'd1 : 32'd0);
        if (p < 512) begin
          check("ura", 32'(upper_read_address), 32'(p));
          check("lra", 32'(lower_read_address), 32'(p));
          if (exp_mode(lm) == 2'd1) begin
            check("ui", 32'(upper_i), 32'(p >> (11 - lm)));
            check("li", 32'(lower_i), 32'(p >> (11 - lm)));
          end
          last = (lm == 1);
          exp_q.push_back({16'(k + 7), 6'd0, 9'(p), last});
        end
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_drop",  32'(busy), 32'd0);
      end
      if (exp_q.size() > 0 && exp_q[0][31:16] == 16'(k)) begin
        e = exp_q.pop_front();
        check("we",  32'(write_enable), 32'd1);
        check("uwa", 32'(upper_write_address), 32'(e[9:1]));
        check("lwa", 32'(lower_write_address), 32'(e[9:1]));
        check("ov",  32'(out_valid), 32'(e[0]));
      end else begin
        check("we_idle", 32'(write_enable), 32'd0);
        check("ov_idle", 32'(out_valid), 32'd0);
      end
    end
  endtask

  initial begin
    int act;
    rst   = 1'b1;
    start = 1'b0;
    step();
    step();
    check_reset_values("rst_hold");
    #1 rst = 1'b0;
    step();
    check_reset_values("post_rst");

    // idle: no activity without start
    act = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (write_enable || busy || out_valid || done) act++;
    end
    check("idle_activity", 32'(act), 32'd0);

    // full run with ignored starts at T+100 and T+6239
    run_checked(TOTAL, 100, TOTAL - 1);
    check("run1_writes_left", 32'(exp_q.size()), 32'd0);

    // start at T+6241 begins a new run; reset it mid-stage at T+3000
    run_checked(2999, -1, -1);
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    exp_q.delete();
    step();
    step();
    check_reset_values("rst_held");
    #1 rst = 1'b0;
    step();
    check("post_rst_we", 32'(write_enable), 32'd0);

    // clean run after reset
    run_checked(TOTAL, -1, -1);
    check("run3_writes_left", 32'(exp_q.size()), 32'd0);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(fsm_state), 32'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
